game_control: RTL and testbench

- Central sequencer for the hit-the-egg game.
- Runs the IDLE/PLAY/OVER flow and the one-second countdown, picks random holes, and detects hits from keypad presses.
- Maintains the score.
- Drives the output display path: position, cnttime, score, color and correct go straight to the LED-matrix and 7-segment scanners; remake comes back from them.

---
 rtl/game_pkg.sv | 25 ++
 rtl/hole_rng.sv | 29 ++
 rtl/game_control.sv | 162 ++++++++++++++++
 tb/tb_game_control.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the hit-the-egg game sequencer.
// Holds the FSM state encoding, LED colour codes, LFSR taps and score limit.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam logic [1:0] COL_OFF = 2'b00;
  localparam logic [1:0] COL_RED = 2'b01;
  localparam logic [1:0] COL_GRN = 2'b10;
  localparam logic [1:0] COL_YEL = 2'b11;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [4:0] SCORE_MAX = 5'd31;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/hole_rng.sv
// Free-running 16-bit Fibonacci LFSR that picks the next hole to light.
// It never pauses, so the hole sequence depends on when the player presses start.
module hole_rng
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_ni,
  output logic [3:0] hole_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign hole_o = lfsr_q[3:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/game_control.sv
// Central sequencer for the hit-the-egg game: IDLE/PLAY/OVER flow, one-second
// countdown, mole spawning/expiry, hit detection and saturating score.
module game_control
  import game_pkg::*;
#(
  parameter int          SEC_DIV   = 1000000,
  parameter int          GAME_SEC  = 60,
  parameter int          MOLE_SEC  = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] key,
  input  logic        remake,
  output logic [16:0] position,
  output logic [5:0]  cnttime,
  output logic [4:0]  score,
  output logic [1:0]  color,
  output logic        correct
);

  localparam int              PW        = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(SEC_DIV - 1);
  localparam logic [5:0]      GAME_INIT = 6'(GAME_SEC);
  localparam logic [3:0]      MOLE_LAST = 4'(MOLE_SEC);

  game_state_e   state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [4:0]    score_q, score_d;
  logic [1:0]    color_q, color_d;
  logic          correct_q, correct_d;
  logic [16:0]   pos_q, pos_d;
  logic [3:0]    age_q, age_d;
  logic [15:0]   key_q;
  logic [15:0]   edge_q;

  logic [3:0]    rng_hole;
  logic [15:0]   rng_oh;
  logic [15:0]   spawn_oh;
  logic          tick;
  logic          hit;
  logic          expire;

  hole_rng #(
    .SEED(LFSR_SEED)
  ) u_rng (
    .clk   (clk),
    .rst_ni(rst),
    .hole_o(rng_hole)
  );

  // A new mole never reappears in the hole it just left.
  assign rng_oh   = onehot16(rng_hole);
  assign spawn_oh = (rng_oh == pos_q[15:0]) ? onehot16(rng_hole + 4'd1) : rng_oh;

  assign tick   = (pre_q == PRE_LAST);
  assign expire = ((age_q + 4'd1) == MOLE_LAST);
  assign hit    = (|edge_q) && (edge_q == pos_q[15:0]) && !pos_q[16];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no branch
    // below can leave one unassigned and infer a latch.
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    score_d   = score_q;
    color_d   = color_q;
    pos_d     = pos_q;
    age_d     = age_q;
    correct_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          pre_d   = '0;
          cnt_d   = GAME_INIT;
          score_d = '0;
          pos_d   = {1'b0, spawn_oh};
          age_d   = '0;
          color_d = COL_RED;
        end
      end

      ST_PLAY: begin
        pre_d = tick ? '0 : pre_q + PW'(1);

        if (tick) begin
          cnt_d = cnt_q - 6'd1;
          age_d = age_q + 4'd1;
          // A scored mole is replaced on the tick after the hit; an unhit one
          // is replaced once it has been up for MOLE_SEC seconds.
          if (!hit && (pos_q[16] || expire)) begin
            pos_d   = {1'b0, spawn_oh};
            age_d   = '0;
            color_d = COL_RED;
          end
        end

        if (hit) begin
          score_d   = (score_q == SCORE_MAX) ? score_q : score_q + 5'd1;
          correct_d = 1'b1;
          pos_d     = {1'b1, pos_q[15:0]};
          color_d   = COL_GRN;
        end

        // The hit above is still scored, but the display asks for a fresh mole.
        if (remake) begin
          pos_d   = {1'b0, spawn_oh};
          age_d   = '0;
          color_d = COL_RED;
        end

        if (tick && (cnt_q == 6'd1)) begin
          state_d = ST_OVER;
          cnt_d   = '0;
          pos_d   = '0;
          color_d = COL_YEL;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      cnt_q     <= GAME_INIT;
      score_q   <= '0;
      color_q   <= COL_OFF;
      correct_q <= 1'b0;
      pos_q     <= '0;
      age_q     <= '0;
      key_q     <= '0;
      edge_q    <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      color_q   <= color_d;
      correct_q <= correct_d;
      pos_q     <= pos_d;
      age_q     <= age_d;
      key_q     <= key;
      edge_q    <= key & ~key_q;
    end
  end

  assign position = pos_q;
  assign cnttime  = cnt_q;
  assign score    = score_q;
  assign color    = color_q;
  assign correct  = correct_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: vector table for whole games plus
// hand-written sequences for mid-game reset and score saturation.
module tb_game_control;

  localparam int          SEC_DIV  = 4;
  localparam int          GAME_SEC = 5;
  localparam int          MOLE_SEC = 2;
  localparam logic [15:0] SEED     = 16'hACE1;

  localparam int K_NONE  = 0;
  localparam int K_HIT   = 1;
  localparam int K_WRONG = 2;
  localparam int K_BOTH  = 3;
  localparam int K_HOLD  = 4;
  localparam int K_ALL   = 5;

  typedef struct {
    bit st;
    int km;
    bit rm;
    int n;
    bit sp;
    int cnt;
    int sc;
    int col;
    bit corr;
    bit hf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, remake;
  logic [15:0] key;
  logic [16:0] position;
  logic [5:0]  cnttime;
  logic [4:0]  score;
  logic [1:0]  color;
  logic        correct;

  logic        start_l, remake_l;
  logic [15:0] key_l;
  logic [16:0] position_l;
  logic [5:0]  cnttime_l;
  logic [4:0]  score_l;
  logic [1:0]  color_l;
  logic        correct_l;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m, lfsr_prev;
  logic [15:0] exp_oh;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  game_control #(
    .SEC_DIV(SEC_DIV), .GAME_SEC(GAME_SEC), .MOLE_SEC(MOLE_SEC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .remake(remake),
    .position(position), .cnttime(cnttime), .score(score), .color(color),
    .correct(correct)
  );

  game_control #(
    .SEC_DIV(SEC_DIV), .GAME_SEC(63), .MOLE_SEC(MOLE_SEC), .LFSR_SEED(SEED)
  ) dut_long (
    .clk(clk), .rst(rst), .start(start_l), .key(key_l), .remake(remake_l),
    .position(position_l), .cnttime(cnttime_l), .score(score_l), .color(color_l),
    .correct(correct_l)
  );

  // Reference hole generator; lfsr_prev is the value the DUT used at the last edge.
  always @(posedge clk) begin
    if (!rst) lfsr_m <= SEED;
    else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    lfsr_prev <= lfsr_m;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_spawn();
    logic [3:0]  h;
    logic [15:0] oh;
    h  = lfsr_prev[3:0];
    oh = 16'd1 << h;
    if (oh == exp_oh) oh = 16'd1 << (h + 4'd1);
    exp_oh = oh;
  endtask

  function automatic vec_t mk(bit st, int km, bit rm, int n, bit sp, int cnt, int sc,
                              int col, bit corr, bit hf);
    vec_t v;
    v.st = st; v.km = km; v.rm = rm; v.n = n; v.sp = sp;
    v.cnt = cnt; v.sc = sc; v.col = col; v.corr = corr; v.hf = hf;
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic [15:0] rot, old_oh;
    logic [16:0] ep;
    int          exp_sc;

    rst = 1'b0; start = 1'b0; remake = 1'b0; key = '0;
    start_l = 1'b0; remake_l = 1'b0; key_l = '0;
    exp_oh = '0;

    // Game 1 from IDLE, no keys: countdown, expiry respawns, game over.
    vecs.push_back(mk(0, K_NONE, 0, 20, 0, 5, 0, 0, 0, 0));
    vecs.push_back(mk(1, K_NONE, 0, 1, 1, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 4, 0, 4, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 1, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 4, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 5, 0, 0, 0, 3, 0, 0));
    // Game 2 from OVER: hit, held key, wrong/double keys, start ignored, hit+remake.
    vecs.push_back(mk(1, K_NONE, 0, 1, 1, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_HIT,  0, 1, 0, 5, 0, 1, 0, 0));
    vecs.push_back(mk(0, K_HOLD, 0, 1, 0, 5, 1, 2, 1, 1));
    vecs.push_back(mk(0, K_HOLD, 0, 1, 0, 5, 1, 2, 0, 1));
    vecs.push_back(mk(0, K_HOLD, 0, 1, 1, 4, 1, 1, 0, 0));
    vecs.push_back(mk(1, K_NONE, 0, 1, 0, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_WRONG, 0, 1, 0, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 0, 4, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_BOTH, 0, 1, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_HIT,  0, 1, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0, K_HOLD, 1, 1, 1, 3, 2, 1, 1, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 0, 2, 2, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 2, 2, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 1, 1, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, K_NONE, 0, 3, 0, 0, 2, 3, 0, 0));
    vecs.push_back(mk(0, K_ALL,  1, 2, 0, 0, 2, 3, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset position", position, 17'd0);
    check("reset cnttime", cnttime, 6'd5);
    check("reset score", score, 5'd0);
    check("reset color", color, 2'b00);
    check("reset correct", correct, 1'b0);
    check("reset long cnttime", cnttime_l, 6'd63);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      for (int k = 0; k < v.n; k++) begin
        rot    = {exp_oh[14:0], exp_oh[15]};
        start  = v.st;
        remake = v.rm;
        case (v.km)
          K_NONE:  key = '0;
          K_HIT:   key = exp_oh;
          K_WRONG: key = rot;
          K_BOTH:  key = exp_oh | rot;
          K_ALL:   key = '1;
          default: ;
        endcase
        step();
        old_oh = exp_oh;
        if (v.sp) begin
          model_spawn();
          if (old_oh != '0) check($sformatf("v%0d hole moved", i), position[15:0] == old_oh, 1'b0);
        end
        if (v.col == 0 || v.col == 3) exp_oh = '0;
        ep = (v.col == 0 || v.col == 3) ? 17'd0 : {v.hf, exp_oh};
        check($sformatf("v%0d.%0d cnttime", i, k), cnttime, v.cnt);
        check($sformatf("v%0d.%0d score", i, k), score, v.sc);
        check($sformatf("v%0d.%0d color", i, k), color, v.col);
        check($sformatf("v%0d.%0d correct", i, k), correct, v.corr);
        check($sformatf("v%0d.%0d position", i, k), position, ep);
      end
    end
    start = 1'b0; remake = 1'b0; key = '0;

    // Mid-game reset at cnttime=3 with a hit in flight: the hit is dropped.
    start = 1'b1;
    step();
    start = 1'b0;
    model_spawn();
    check("rst game start position", position, {1'b0, exp_oh});
    repeat (8) step();
    check("rst precondition cnttime", cnttime, 6'd3);
    key = exp_oh;
    step();
    rst = 1'b0;
    key = '0;
    step();
    exp_oh = '0;
    check("midrst position", position, 17'd0);
    check("midrst cnttime", cnttime, 6'd5);
    check("midrst score", score, 5'd0);
    check("midrst color", color, 2'b00);
    check("midrst correct", correct, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("post-rst seed hole", position, 17'h00002);
    check("post-rst cnttime", cnttime, 6'd5);
    check("post-rst color", color, 2'b01);

    // Score saturation on the long-game instance: hit+remake every 3 cycles.
    exp_sc = 0;
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    for (int i = 0; i < 34; i++) begin
      key_l = position_l[15:0];
      step();
      remake_l = 1'b1;
      step();
      exp_sc = (exp_sc == 31) ? 31 : exp_sc + 1;
      check($sformatf("sat%0d correct", i), correct_l, 1'b1);
      check($sformatf("sat%0d score", i), score_l, exp_sc);
      check($sformatf("sat%0d flag", i), position_l[16], 1'b0);
      remake_l = 1'b0;
      key_l = '0;
      step();
      check($sformatf("sat%0d correct drop", i), correct_l, 1'b0);
    end
    check("sat still playing", cnttime_l != 6'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
